// File: rtl/pulse_catch_sched.sv
// Config sequencer and round-robin event scheduler for a bank of PulseCatch channels.
// Optional PULSE_SCHED_TS_EN adds a free-running timestamp per captured edge.
module pulse_catch_sched #(
    parameter int CH_NUM     = 4,
    parameter int _RAM_WIDTH = 32,
    parameter int TS_WIDTH   = 16,
    localparam int CHW       = $clog2(CH_NUM)
) (
    input  logic                         io_clk,
    input  logic                         io_rst,
    input  logic                         io_cfg_valid,
    output logic                         io_cfg_ready,
    input  logic [CHW-1:0]               io_cfg_ch,
    input  logic [_RAM_WIDTH-1:0]        io_cfg_filterCnt,
    input  logic                         io_cfg_defaultLevel,
    input  logic                         io_cfg_enable,
    output logic [CH_NUM*_RAM_WIDTH-1:0] io_filterCnt,
    output logic [CH_NUM-1:0]            io_defaultLevel,
    output logic [CH_NUM-1:0]            io_ch_rst,
    input  logic [CH_NUM-1:0]            io_fb_catch,
    output logic                         io_evt_valid,
    input  logic                         io_evt_ready,
    output logic [CHW-1:0]               io_evt_ch,
    output logic [TS_WIDTH-1:0]          io_evt_ts,
    output logic [CH_NUM-1:0]            io_ovf,
    input  logic                         io_ovf_clr
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_APPLY0,
        S_APPLY1,
        S_SETTLE
    } state_t;

    localparam logic [CH_NUM-1:0] ONE = {{(CH_NUM-1){1'b0}}, 1'b1};

    state_t                               state_q, state_d;
    logic [CHW-1:0]                       cfg_ch_q, cfg_ch_d;
    logic                                 cfg_hit_q, cfg_hit_d;
    logic [CH_NUM-1:0][_RAM_WIDTH-1:0]    filt_q, filt_d;
    logic [CH_NUM-1:0]                    dlvl_q, dlvl_d;
    logic [CH_NUM-1:0]                    en_q, en_d;
    logic [CH_NUM-1:0]                    catch_q, catch_d;
    logic [CH_NUM-1:0]                    pend_q, pend_d;
    logic [CH_NUM-1:0]                    ovf_q, ovf_d;
    logic [CHW-1:0]                       rr_q, rr_d;
    logic                                 evt_valid_q, evt_valid_d;
    logic [CHW-1:0]                       evt_ch_q, evt_ch_d;

    logic              cfg_acc;
    logic [CH_NUM-1:0] acc_mask;
    logic [CH_NUM-1:0] cfg_mask;
    logic [CH_NUM-1:0] busy_mask;
    logic [CH_NUM-1:0] ch_rst;
    logic [CH_NUM-1:0] edge_v;
    logic [CH_NUM-1:0] pop_mask;
    logic              load;
    logic              found;
    logic              pop;
    logic [CHW-1:0]    pick;
    int unsigned       sel;

`ifdef PULSE_SCHED_TS_EN
    logic [TS_WIDTH-1:0]               ts_cnt_q, ts_cnt_d;
    logic [CH_NUM-1:0][TS_WIDTH-1:0]   ts_q, ts_d;
    logic [TS_WIDTH-1:0]               evt_ts_q, evt_ts_d;
`endif

    assign cfg_mask  = cfg_hit_q ? (ONE << cfg_ch_q) : '0;
    assign busy_mask = (state_q == S_APPLY0 || state_q == S_APPLY1 ||
                        state_q == S_SETTLE) ? cfg_mask : '0;
    assign acc_mask  = (cfg_acc && cfg_hit_d) ? (ONE << io_cfg_ch) : '0;

    always_comb begin
        state_d   = state_q;
        cfg_ch_d  = cfg_ch_q;
        cfg_hit_d = cfg_hit_q;
        filt_d    = filt_q;
        dlvl_d    = dlvl_q;
        en_d      = en_q;
        cfg_acc   = 1'b0;
        ch_rst    = '0;
        io_cfg_ready = 1'b0;
        unique case (state_q)
            S_INIT: begin
                ch_rst  = '1;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                io_cfg_ready = 1'b1;
                if (io_cfg_valid) begin
                    cfg_acc   = 1'b1;
                    cfg_ch_d  = io_cfg_ch;
                    cfg_hit_d = (int'(io_cfg_ch) < CH_NUM);
                    if (int'(io_cfg_ch) < CH_NUM) begin
                        filt_d[io_cfg_ch] = io_cfg_filterCnt;
                        dlvl_d[io_cfg_ch] = io_cfg_defaultLevel;
                        en_d[io_cfg_ch]   = io_cfg_enable;
                    end
                    state_d = S_APPLY0;
                end
            end
            S_APPLY0: begin
                ch_rst  = cfg_mask;
                state_d = S_APPLY1;
            end
            S_APPLY1: begin
                ch_rst  = cfg_mask;
                state_d = S_SETTLE;
            end
            S_SETTLE: state_d = S_IDLE;
            default:  state_d = S_INIT;
        endcase
    end

    // Round-robin search starting at the pointer
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sel   = 0;
        for (int k = 0; k < CH_NUM; k++) begin
            sel = (int'(rr_q) + k) % CH_NUM;
            if (!found && pend_q[sel]) begin
                found = 1'b1;
                pick  = CHW'(sel);
            end
        end
    end

    assign load     = !evt_valid_q || io_evt_ready;
    assign pop      = load && found;
    assign pop_mask = pop ? (ONE << pick) : '0;
    assign catch_d  = io_fb_catch;
    assign edge_v   = io_fb_catch & ~catch_q & en_q & ~busy_mask;

    always_comb begin
        evt_valid_d = load ? found : evt_valid_q;
        evt_ch_d    = pop ? pick : evt_ch_q;
        rr_d        = rr_q;
        if (pop)
            rr_d = (int'(pick) == CH_NUM - 1) ? '0 : pick + 1'b1;
        pend_d = pend_q & ~pop_mask;
        ovf_d  = io_ovf_clr ? '0 : ovf_q;
`ifdef PULSE_SCHED_TS_EN
        ts_cnt_d = ts_cnt_q + 1'b1;
        ts_d     = ts_q;
        evt_ts_d = pop ? ts_q[pick] : evt_ts_q;
`endif
        // A slot popped this cycle is free again, so a new edge refills it
        for (int i = 0; i < CH_NUM; i++) begin
            if (edge_v[i]) begin
                if (pend_q[i] && !pop_mask[i]) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
`ifdef PULSE_SCHED_TS_EN
                    ts_d[i] = ts_cnt_q;
`endif
                end
            end
        end
        pend_d = pend_d & ~acc_mask;
    end

    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            state_q     <= S_INIT;
            cfg_ch_q    <= '0;
            cfg_hit_q   <= 1'b0;
            filt_q      <= '0;
            dlvl_q      <= '0;
            en_q        <= '0;
            catch_q     <= '0;
            pend_q      <= '0;
            ovf_q       <= '0;
            rr_q        <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            cfg_ch_q    <= cfg_ch_d;
            cfg_hit_q   <= cfg_hit_d;
            filt_q      <= filt_d;
            dlvl_q      <= dlvl_d;
            en_q        <= en_d;
            catch_q     <= catch_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            rr_q        <= rr_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
        end
    end

`ifdef PULSE_SCHED_TS_EN
    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
            evt_ts_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            ts_q     <= ts_d;
            evt_ts_q <= evt_ts_d;
        end
    end
    assign io_evt_ts = evt_ts_q;
`else
    assign io_evt_ts = '0;
`endif

    assign io_filterCnt    = filt_q;
    assign io_defaultLevel = dlvl_q;
    assign io_ch_rst       = ch_rst;
    assign io_evt_valid    = evt_valid_q;
    assign io_evt_ch       = evt_ch_q;
    assign io_ovf          = ovf_q;

endmodule

// File: tb/tb_pulse_catch_sched.sv
// Directed bench for pulse_catch_sched: config sequencing, RR ordering,
// overflow, disable and reset behaviour.
module tb_pulse_catch_sched;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [31:0]   cfg_fc;
    logic          cfg_dl;
    logic          cfg_en;
    logic [127:0]  filt;
    logic [3:0]    dlvl;
    logic [3:0]    ch_rst;
    logic [3:0]    fb;
    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_ch;
    logic [15:0]   evt_ts;
    logic [3:0]    ovf;
    logic          ovf_clr;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] tb_cnt;
    logic [15:0] t0, t1, t2;

    pulse_catch_sched dut (
        .io_clk              (clk),
        .io_rst              (rst),
        .io_cfg_valid        (cfg_valid),
        .io_cfg_ready        (cfg_ready),
        .io_cfg_ch           (cfg_ch),
        .io_cfg_filterCnt    (cfg_fc),
        .io_cfg_defaultLevel (cfg_dl),
        .io_cfg_enable       (cfg_en),
        .io_filterCnt        (filt),
        .io_defaultLevel     (dlvl),
        .io_ch_rst           (ch_rst),
        .io_fb_catch         (fb),
        .io_evt_valid        (evt_valid),
        .io_evt_ready        (evt_ready),
        .io_evt_ch           (evt_ch),
        .io_evt_ts           (evt_ts),
        .io_ovf              (ovf),
        .io_ovf_clr          (ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference free-running cycle count since reset release
    always @(posedge clk) begin
        if (rst) tb_cnt <= 16'h0;
        else     tb_cnt <= tb_cnt + 16'h1;
    end

    function automatic logic [31:0] ets(input logic [15:0] t);
`ifdef PULSE_SCHED_TS_EN
        return {16'h0, t};
`else
        return 32'h0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [31:0] fc,
                             input logic dl, input logic en);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_fc    = fc;
        cfg_dl    = dl;
        cfg_en    = en;
        cyc(1);
        cfg_valid = 1'b0;
        cyc(3);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_fc    = 32'd0;
        cfg_dl    = 1'b0;
        cfg_en    = 1'b0;
        fb        = 4'h0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        cyc(3);
        check("rst_ch_rst", {28'h0, ch_rst}, 32'hF);
        check("rst_ready", {31'h0, cfg_ready}, 32'h0);
        check("rst_valid", {31'h0, evt_valid}, 32'h0);
        check("rst_ovf", {28'h0, ovf}, 32'h0);
        check("rst_filt", filt[95:64], 32'h0);
        check("rst_ts", {16'h0, evt_ts}, 32'h0);
        rst = 1'b0;
        cyc(1);
        check("init_ch_rst", {28'h0, ch_rst}, 32'h0);
        check("init_ready", {31'h0, cfg_ready}, 32'h1);

        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_fc    = 32'd10;
        cfg_dl    = 1'b0;
        cfg_en    = 1'b1;
        cyc(1);
        cfg_valid = 1'b0;
        check("cfg2_filt", filt[95:64], 32'd10);
        check("cfg2_rst_a", {28'h0, ch_rst}, 32'h4);
        check("cfg2_rdy_a", {31'h0, cfg_ready}, 32'h0);
        cyc(1);
        check("cfg2_rst_b", {28'h0, ch_rst}, 32'h4);
        check("cfg2_rdy_b", {31'h0, cfg_ready}, 32'h0);
        cyc(1);
        check("cfg2_rst_c", {28'h0, ch_rst}, 32'h0);
        check("cfg2_rdy_c", {31'h0, cfg_ready}, 32'h0);
        cyc(1);
        check("cfg2_rdy_d", {31'h0, cfg_ready}, 32'h1);

        cfg_write(2'd0, 32'd5, 1'b0, 1'b1);
        cfg_write(2'd1, 32'd7, 1'b1, 1'b1);
        cfg_write(2'd3, 32'd9, 1'b0, 1'b1);
        check("dlvl", {28'h0, dlvl}, 32'h2);
        check("filt0", filt[31:0], 32'd5);
        check("filt3", filt[127:96], 32'd9);

        // Simultaneous edges drain in channel order, one per cycle
        evt_ready = 1'b1;
        fb = 4'b1011;
        t0 = tb_cnt;
        cyc(1);
        fb = 4'h0;
        check("lat_valid", {31'h0, evt_valid}, 32'h0);
        cyc(1);
        check("b_v0", {31'h0, evt_valid}, 32'h1);
        check("b_ch0", {30'h0, evt_ch}, 32'd0);
        check("b_ts0", {16'h0, evt_ts}, ets(t0));
        cyc(1);
        check("b_ch1", {30'h0, evt_ch}, 32'd1);
        check("b_ts1", {16'h0, evt_ts}, ets(t0));
        cyc(1);
        check("b_v3", {31'h0, evt_valid}, 32'h1);
        check("b_ch3", {30'h0, evt_ch}, 32'd3);
        check("b_ts3", {16'h0, evt_ts}, ets(t0));
        cyc(1);
        check("b_empty", {31'h0, evt_valid}, 32'h0);

        // Stalled consumer: output holds one, pending holds one, third overflows
        evt_ready = 1'b0;
        fb = 4'b0010;
        t1 = tb_cnt;
        cyc(1);
        fb = 4'h0;
        cyc(1);
        fb = 4'b0010;
        t2 = tb_cnt;
        cyc(1);
        fb = 4'h0;
        cyc(1);
        fb = 4'b0010;
        cyc(1);
        fb = 4'h0;
        check("ovf_set", {28'h0, ovf}, 32'h2);
        check("hold_v", {31'h0, evt_valid}, 32'h1);
        check("hold_ch", {30'h0, evt_ch}, 32'd1);
        check("hold_ts", {16'h0, evt_ts}, ets(t1));
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        check("ovf_clr", {28'h0, ovf}, 32'h0);
        check("hold_ch2", {30'h0, evt_ch}, 32'd1);
        evt_ready = 1'b1;
        cyc(1);
        check("ovf_v2", {31'h0, evt_valid}, 32'h1);
        check("ovf_ch2", {30'h0, evt_ch}, 32'd1);
        check("ovf_ts2", {16'h0, evt_ts}, ets(t2));
        cyc(1);
        check("ovf_empty", {31'h0, evt_valid}, 32'h0);

        // Pointer now sits past ch1
        fb = 4'b1011;
        t0 = tb_cnt;
        cyc(1);
        fb = 4'h0;
        cyc(1);
        check("rr_ch3", {30'h0, evt_ch}, 32'd3);
        check("rr_ts3", {16'h0, evt_ts}, ets(t0));
        cyc(1);
        check("rr_ch0", {30'h0, evt_ch}, 32'd0);
        cyc(1);
        check("rr_ch1", {30'h0, evt_ch}, 32'd1);
        check("rr_v1", {31'h0, evt_valid}, 32'h1);
        cyc(1);
        check("rr_empty", {31'h0, evt_valid}, 32'h0);

        cfg_write(2'd0, 32'd5, 1'b0, 1'b0);
        fb = 4'b0001;
        cyc(1);
        fb = 4'h0;
        cyc(3);
        check("dis_valid", {31'h0, evt_valid}, 32'h0);
        check("dis_ovf", {28'h0, ovf}, 32'h0);

        evt_ready = 1'b0;
        fb = 4'b1110;
        cyc(1);
        fb = 4'h0;
        cyc(1);
        check("q_valid", {31'h0, evt_valid}, 32'h1);
        check("q_ch", {30'h0, evt_ch}, 32'd2);
        rst = 1'b1;
        cyc(1);
        check("mrst_valid", {31'h0, evt_valid}, 32'h0);
        check("mrst_ch", {30'h0, evt_ch}, 32'd0);
        check("mrst_ch_rst", {28'h0, ch_rst}, 32'hF);
        check("mrst_filt", filt[95:64], 32'h0);
        rst = 1'b0;
        evt_ready = 1'b1;
        cyc(1);
        check("mrst_rel", {28'h0, ch_rst}, 32'h0);
        cyc(3);
        check("mrst_drain", {31'h0, evt_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
